// File: rtl/int_prio_pkg.sv
// Shared definitions for the interrupt priority encoder: line count, code width,
// controller states and a one-hot helper used to clear a granted line.
package int_prio_pkg;

  localparam int NREQ   = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // One-hot mask selecting the line addressed by a grant code.
  function automatic logic [NREQ-1:0] code_onehot(input logic [CODE_W-1:0] code);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8:3 priority encoder; the highest set bit wins (bit 7 highest).
module prio_enc8
  import int_prio_pkg::*;
(
  input  logic [7:0]        vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  always_comb begin
    idx_o = '0;
    // Ascending scan so a later (higher) set bit overrides a lower one.
    for (int i = 0; i < 8; i++) begin
      if (vec_i[i]) idx_o = CODE_W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/int_prio_encoder.sv
// Edge-latched interrupt priority encoder with a valid/ack code handshake.
// Optional two-flop request synchronizer: define INT_PRIO_SYNC_EN.
module int_prio_encoder #(
  parameter int NREQ = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        mask,
  input  logic                   ei,
  input  logic                   ack,
  output logic                   valid,
  output logic [2:0]             code,
  output logic                   gs,
  output logic [NREQ-1:0]        pend,
  output int_prio_pkg::state_e   dbg_state
);

  import int_prio_pkg::CODE_W;
  import int_prio_pkg::state_e;
  import int_prio_pkg::IDLE;
  import int_prio_pkg::PRESENT;
  import int_prio_pkg::code_onehot;

  // Handshake: valid rises with a stable code; the consumer pulses ack while
  // valid=1 and the code is retired on that edge. ack while valid=0 is ignored.

  logic [NREQ-1:0] req_s;

`ifdef INT_PRIO_SYNC_EN
  localparam logic [1:0] ARM_EDGES = 2'd3;

  logic [NREQ-1:0] sync1_q;
  logic [NREQ-1:0] sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  localparam logic [1:0] ARM_EDGES = 2'd1;

  assign req_s = req;
`endif

  logic [NREQ-1:0]   prev_q;
  logic [NREQ-1:0]   pend_q;
  logic [NREQ-1:0]   pend_d;
  logic [NREQ-1:0]   rise;
  logic [NREQ-1:0]   clr;
  logic [1:0]        arm_q;
  logic              armed;
  state_e            state_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic [CODE_W-1:0] sel_idx;
  logic              sel_any;

  // Edge detection stays off until prev_q holds a genuine sample of req_s, so
  // lines already high when reset releases are not mistaken for new edges.
  assign armed = (arm_q == ARM_EDGES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_q  <= '0;
      prev_q <= '0;
    end else begin
      if (!armed) arm_q <= arm_q + 2'd1;
      prev_q <= req_s;
    end
  end

  assign rise = armed ? (req_s & ~prev_q) : '0;
  assign clr  = (state_q == PRESENT && ack) ? code_onehot(code_q) : '0;

  // A new edge on the retiring line wins over its clear.
  assign pend_d = (pend_q & ~clr) | rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  prio_enc8 u_enc (
    .vec_i (pend_q & mask),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ei && sel_any) begin
            code_q  <= sel_idx;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign valid     = valid_q;
  assign code      = code_q;
  assign gs        = sel_any;
  assign pend      = pend_q;
  assign dbg_state = state_q;

endmodule
